dm_axi_master: RTL and testbench

Bridges the CPU data-memory port (DM_MEM_access/DM_WEB/DM_write/DM_addr/DM_data_in → DM_out/DM_stall) onto an AXI4 master port toward the system bus. Converts each CPU access into one single-beat AXI read or write, holds the pipeline via DM_stall until the transaction completes, and returns read data. Sits directly downstream of the CPU's MEM stage, between the CPU and the bus interconnect.

---
 rtl/dm_axi_pkg.sv | 27 ++
 rtl/dm_axi_master.sv | 210 +++++++++++++++++++++
 tb/tb_dm_axi_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_axi_pkg.sv
// dm_axi_pkg: shared types and AXI constants for the CPU data-memory to AXI4 bridge.
//   dm_state_e   - bridge FSM states
//   SIZE_WORD    - AxSIZE for a 32-bit beat
//   BURST_INCR   - AxBURST encoding used for every request
//   LEN_SINGLE   - AxLEN for a single-beat transfer
//   RESP_OKAY    - xRESP value treated as success
package dm_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp,
        StDone
    } dm_state_e;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] LEN_SINGLE = 4'd0;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/dm_axi_master.sv
// dm_axi_master: turns each CPU data-memory access into one single-beat AXI4 read or write and
// stalls the CPU until it completes.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   DM_MEM_access       - CPU request valid (held with its fields while DM_stall=1)
//   DM_WEB              - 1 = read, 0 = write
//   DM_write            - active-low byte write enables
//   DM_addr, DM_data_in - byte address (passed through) and write data
//   DM_out              - registered read data
//   DM_stall            - DM_MEM_access && !done
//   bus_err             - sticky flag, set by any non-OKAY RRESP/BRESP
//   AR/R/AW/W/B         - AXI4 master channels (single beat, INCR, 32-bit)
//
// Build option: CPU_POSTED_WRITE_EN - writes complete to the CPU after the AW and W handshakes;
// the B response is collected in the background and blocks the next request until it arrives.
module dm_axi_master
    import dm_axi_pkg::*;
#(
    parameter int unsigned             ID_WIDTH  = 4,
    parameter logic [ID_WIDTH-1:0]     MASTER_ID = ID_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    // CPU data-memory port
    input  logic                DM_MEM_access,
    input  logic                DM_WEB,
    input  logic [3:0]          DM_write,
    input  logic [31:0]         DM_addr,
    input  logic [31:0]         DM_data_in,
    output logic [31:0]         DM_out,
    output logic                DM_stall,
    output logic                bus_err,
    // AR channel
    output logic [ID_WIDTH-1:0] ARID,
    output logic [31:0]         ARADDR,
    output logic [3:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    // R channel
    input  logic [ID_WIDTH-1:0] RID,
    input  logic [31:0]         RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    // AW channel
    output logic [ID_WIDTH-1:0] AWID,
    output logic [31:0]         AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    // W channel
    output logic [31:0]         WDATA,
    output logic [3:0]          WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    // B channel
    input  logic [ID_WIDTH-1:0] BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    dm_state_e   state_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [31:0] dm_out_q;
    logic        bus_err_q;
    logic        req_block;

    // IDs and RLAST are not checked; single-beat reads need no RLAST tracking.
    logic unused_inputs;
    assign unused_inputs = ^{RID, BID, RLAST};

    // A channel counts as finished if it handshook earlier or is handshaking now.
    logic aw_fin;
    logic w_fin;
    assign aw_fin = aw_done_q | (awvalid_q & AWREADY);
    assign w_fin  = w_done_q | (wvalid_q & WREADY);

`ifdef CPU_POSTED_WRITE_EN
    logic pending_b_q;
    assign req_block = pending_b_q;
`else
    assign req_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            dm_out_q  <= 32'd0;
            bus_err_q <= 1'b0;
`ifdef CPU_POSTED_WRITE_EN
            pending_b_q <= 1'b0;
`endif
        end else begin
`ifdef CPU_POSTED_WRITE_EN
            // Background collection of the posted write's response.
            if (pending_b_q && BVALID) begin
                pending_b_q <= 1'b0;
                bready_q    <= 1'b0;
                if (resp_is_err(BRESP)) bus_err_q <= 1'b1;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (DM_MEM_access && !req_block) begin
                        if (DM_WEB) begin
                            state_q   <= StRdAddr;
                            arvalid_q <= 1'b1;
                        end else begin
                            state_q   <= StWrReq;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end
                    end
                end
                StRdAddr: begin
                    if (arvalid_q && ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (RVALID) begin
                        rready_q <= 1'b0;
                        dm_out_q <= RDATA;
                        if (resp_is_err(RRESP)) bus_err_q <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StWrReq: begin
                    if (awvalid_q && AWREADY) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && WREADY) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
`ifdef CPU_POSTED_WRITE_EN
                        pending_b_q <= 1'b1;
                        state_q     <= StDone;
`else
                        state_q     <= StWrResp;
`endif
                    end
                end
                StWrResp: begin
                    if (BVALID) begin
                        bready_q <= 1'b0;
                        if (resp_is_err(BRESP)) bus_err_q <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign DM_stall = DM_MEM_access && (state_q != StDone);
    assign DM_out   = dm_out_q;
    assign bus_err  = bus_err_q;

    assign ARID    = MASTER_ID;
    assign ARADDR  = DM_addr;
    assign ARLEN   = LEN_SINGLE;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

    assign AWID    = MASTER_ID;
    assign AWADDR  = DM_addr;
    assign AWLEN   = LEN_SINGLE;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign AWVALID = awvalid_q;

    assign WDATA  = DM_data_in;
    assign WSTRB  = ~DM_write;
    assign WLAST  = 1'b1;
    assign WVALID = wvalid_q;
    assign BREADY = bready_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// tb_dm_axi_master: scoreboard bench for dm_axi_master. A driver issues CPU accesses against a
// programmable-latency AXI slave and pushes the expected outcome (stall length, read data,
// bus_err) derived from latency arithmetic; a monitor pops and compares on completion and
// checks AR/AW/W payloads against queued expectations while VALID is high.
module tb_dm_axi_master;

`ifdef CPU_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        DM_MEM_access = 1'b0;
    logic        DM_WEB = 1'b1;
    logic [3:0]  DM_write = 4'hf;
    logic [31:0] DM_addr = 32'd0;
    logic [31:0] DM_data_in = 32'd0;
    logic [31:0] DM_out;
    logic        DM_stall;
    logic        bus_err;
    logic [3:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    dm_axi_master dut (
        .clk(clk), .rst(rst),
        .DM_MEM_access(DM_MEM_access), .DM_WEB(DM_WEB), .DM_write(DM_write),
        .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_out(DM_out), .DM_stall(DM_stall),
        .bus_err(bus_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // ---------------- slave with per-transaction latency knobs ----------------
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rdata_k = 32'd0;
    logic [1:0]  rresp_k = 2'b00, bresp_k = 2'b00;

    int          ar_cnt, aw_cnt, w_cnt, r_left, b_left;
    logic        aw_seen, w_seen, rvalid_q, bvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q, bresp_q;
    logic        aw_hs, w_hs, b_busy;

    assign ARREADY = ARVALID && (ar_cnt >= ar_dly);
    assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
    assign WREADY  = WVALID && (w_cnt >= w_dly);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign b_busy  = bvalid_q || (b_left != 0) || aw_seen || w_seen;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = 1'b1;
    assign RID     = 4'd1;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign BID     = 4'd1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_left <= 0; b_left <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; rvalid_q <= 1'b0; bvalid_q <= 1'b0;
            rdata_q <= 32'd0; rresp_q <= 2'b00; bresp_q <= 2'b00;
        end else begin
            if (ARVALID && !ARREADY) ar_cnt <= ar_cnt + 1;
            else if (ARVALID && ARREADY) begin
                ar_cnt  <= 0;
                rdata_q <= rdata_k;
                rresp_q <= rresp_k;
                if (r_dly == 0) rvalid_q <= 1'b1;
                else r_left <= r_dly;
            end
            if (r_left != 0) begin
                r_left <= r_left - 1;
                if (r_left == 1) rvalid_q <= 1'b1;
            end
            if (rvalid_q && RREADY) rvalid_q <= 1'b0;

            if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1;
            else if (aw_hs) aw_cnt <= 0;
            if (WVALID && !WREADY) w_cnt <= w_cnt + 1;
            else if (w_hs) w_cnt <= 0;
            if (aw_hs) aw_seen <= 1'b1;
            if (w_hs) w_seen <= 1'b1;
            // Response becomes due once both address and data have been accepted.
            if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
                bresp_q <= bresp_k;
                if (b_dly == 0) bvalid_q <= 1'b1;
                else b_left <= b_dly;
            end
            if (b_left != 0) begin
                b_left <= b_left - 1;
                if (b_left == 1) bvalid_q <= 1'b1;
            end
            if (bvalid_q && BREADY) bvalid_q <= 1'b0;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit          rd;
        logic [31:0] data;
        logic        err;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic        model_err = 1'b0;
    int          prev_b = -1;   // B latency of an outstanding posted write, -1 if none
    int          stall_cnt = 0;

    // Stall length = request cycle + cycles in each waiting phase (each phase takes its slave
    // delay plus one), plus any wait for a previous posted write response.
    task automatic access(input bit rd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] we, input int ard, input int rdd, input int awd,
                          input int wd, input int bd, input logic [31:0] rdat,
                          input logic [1:0] rr, input logic [1:0] br, input int gap);
        exp_t e;
        int   extra;
        bit   done;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        ar_dly = ard; r_dly = rdd; aw_dly = awd; w_dly = wd; b_dly = bd;
        rdata_k = rdat; rresp_k = rr; bresp_k = br;
        DM_WEB = rd; DM_addr = addr; DM_data_in = data; DM_write = we;
        DM_MEM_access = 1'b1;
        extra = (POSTED && prev_b > gap) ? prev_b - gap : 0;
        e.rd = rd;
        e.data = rdat;
        if (rd) begin
            e.stall = 1 + extra + (ard + 1) + (rdd + 1);
            if (rr != 2'b00) model_err = 1'b1;
            e.err = model_err;
            ar_q.push_back(addr);
            prev_b = -1;
        end else begin
            e.stall = 1 + extra + ((awd > wd) ? awd : wd) + 1 + (POSTED ? 0 : bd + 1);
            if (POSTED) begin
                e.err = model_err;
                if (br != 2'b00) model_err = 1'b1;
                prev_b = bd;
            end else begin
                if (br != 2'b00) model_err = 1'b1;
                e.err = model_err;
            end
            aw_q.push_back(addr);
            w_q.push_back({data, ~we});
        end
        exp_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!DM_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            fail_now("access_timeout");
            finish_run();
        end
        @(posedge clk);
        #1;
        DM_MEM_access = 1'b0;
    endtask

    initial begin : monitor
        bit   pav, paw, pw;
        exp_t e;
        pav = 1'b0; paw = 1'b0; pw = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_cnt = 0;
                pav = 1'b0; paw = 1'b0; pw = 1'b0;
            end else begin
                // VALID must stay up until its handshake.
                if (pav) chk("arvalid_held", 32'(ARVALID), 32'd1);
                if (paw) chk("awvalid_held", 32'(AWVALID), 32'd1);
                if (pw)  chk("wvalid_held", 32'(WVALID), 32'd1);
                if (ARVALID) begin
                    if (ar_q.size() == 0) fail_now("unexpected_arvalid");
                    else begin
                        chk("araddr", ARADDR, ar_q[0]);
                        if (ARREADY) begin
                            chk("ar_fixed", 32'({ARID, ARLEN, ARSIZE, ARBURST}),
                                32'({4'd1, 4'd0, 3'b010, 2'b01}));
                            chk("ar_while_b_pending", 32'(b_busy), 32'd0);
                            void'(ar_q.pop_front());
                        end
                    end
                end
                if (AWVALID) begin
                    if (aw_q.size() == 0) fail_now("unexpected_awvalid");
                    else begin
                        chk("awaddr", AWADDR, aw_q[0]);
                        if (AWREADY) begin
                            chk("aw_fixed", 32'({AWID, AWLEN, AWSIZE, AWBURST}),
                                32'({4'd1, 4'd0, 3'b010, 2'b01}));
                            void'(aw_q.pop_front());
                        end
                    end
                end
                if (WVALID) begin
                    if (w_q.size() == 0) fail_now("unexpected_wvalid");
                    else begin
                        chk("wdata", WDATA, w_q[0][35:4]);
                        chk("wstrb_wlast", 32'({WSTRB, WLAST}), 32'({w_q[0][3:0], 1'b1}));
                        if (WREADY) void'(w_q.pop_front());
                    end
                end
                pav = ARVALID && !ARREADY;
                paw = AWVALID && !AWREADY;
                pw  = WVALID && !WREADY;
                if (DM_MEM_access) begin
                    if (DM_stall) stall_cnt++;
                    else begin
                        if (exp_q.size() == 0) fail_now("unexpected_completion");
                        else begin
                            e = exp_q.pop_front();
                            chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                            if (e.rd) chk("dm_out", DM_out, e.data);
                            chk("bus_err", 32'(bus_err), 32'(e.err));
                        end
                        stall_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic rand_access(input bit with_err);
        logic [1:0] rr, br;
        rr = (with_err && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        br = (with_err && $urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
        access(1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc, $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
               rr, br, $urandom_range(0, 2));
    endtask

    initial begin : watchdog
        #300000;
        fail_now("global_timeout");
        finish_run();
    end

    initial begin : stimulus
        bit seen;
        // Reset state; DM_stall follows DM_MEM_access even in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
        chk("rst_dm_out", DM_out, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        DM_MEM_access = 1'b1;
        #1;
        chk("rst_stall_follows", 32'(DM_stall), 32'd1);
        DM_MEM_access = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(DM_stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait read: 3 stall cycles.
        access(1'b1, 32'h0001_0004, 32'd0, 4'hf, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00, 0);
        // Write with WREADY three cycles ahead of AWREADY.
        access(1'b0, 32'h0002_0000, 32'h1234_5678, 4'b1100, 0, 0, 3, 0, 0, 32'd0, 2'b00,
               2'b00, 0);
        // ARREADY low for the request cycle plus nine address cycles: 12 stall cycles.
        access(1'b1, 32'h0003_0010, 32'd0, 4'hf, 9, 0, 0, 0, 0, 32'hA5A5_0001, 2'b00, 2'b00,
               0);
        // Write with slow B followed at once by a read.
        access(1'b0, 32'h0004_0000, 32'hCAFE_F00D, 4'b0000, 0, 0, 0, 0, 5, 32'd0, 2'b00,
               2'b00, 0);
        access(1'b1, 32'h0004_0000, 32'd0, 4'hf, 0, 0, 0, 0, 0, 32'h0BAD_CAFE, 2'b00, 2'b00,
               0);

        for (int i = 0; i < 30; i++) rand_access(1'b0);

        // Error response: still completes, bus_err stays set through later OKAY accesses.
        access(1'b1, 32'h0005_0000, 32'd0, 4'hf, 1, 1, 0, 0, 0, 32'h1111_2222, 2'b10, 2'b00,
               0);
        access(1'b0, 32'h0005_0004, 32'h3333_4444, 4'b1010, 0, 0, 1, 2, 1, 32'd0, 2'b00,
               2'b00, 0);
        access(1'b1, 32'h0005_0008, 32'd0, 4'hf, 0, 2, 0, 0, 0, 32'h5555_6666, 2'b00, 2'b00,
               1);

        // Reset while a read is waiting for RVALID.
        repeat (8) @(posedge clk);
        #1;
        ar_dly = 0; r_dly = 6; rdata_k = 32'h7777_8888; rresp_k = 2'b00;
        DM_WEB = 1'b1; DM_addr = 32'h0006_0000; DM_MEM_access = 1'b1;
        ar_q.push_back(32'h0006_0000);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (RREADY) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("rready_timeout");
        #2;
        rst = 1'b0;
        DM_MEM_access = 1'b0;
        #1;
        chk("midrst_ar_r", 32'({ARVALID, RREADY}), 32'd0);
        chk("midrst_dm_out", DM_out, 32'd0);
        chk("midrst_bus_err", 32'(bus_err), 32'd0);
        chk("midrst_stall", 32'(DM_stall), 32'd0);
        exp_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
        model_err = 1'b0;
        prev_b = -1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Recovery, write-response error, then random traffic with errors.
        access(1'b1, 32'h0007_0000, 32'd0, 4'hf, 0, 0, 0, 0, 0, 32'h9999_0000, 2'b00, 2'b00, 0);
        access(1'b0, 32'h0007_0004, 32'h0F0F_0F0F, 4'b0110, 0, 0, 0, 0, 0, 32'd0, 2'b00,
               2'b11, 0);
        access(1'b1, 32'h0007_0008, 32'd0, 4'hf, 0, 0, 0, 0, 0, 32'h1357_9BDF, 2'b00, 2'b00, 0);
        for (int i = 0; i < 10; i++) rand_access(1'b1);

        repeat (10) @(posedge clk);
        if (exp_q.size() != 0) fail_now("scoreboard_not_drained");
        finish_run();
    end

endmodule
